alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/alu_unit.sv | 59 +++++
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: requester count, field widths,
// opcode encoding and response flag bit positions.
package alu_pkg;

  localparam int NREQ    = 4;
  localparam int ID_W    = 2;
  localparam int OP_W    = 3;
  localparam int DATA_W  = 4;
  localparam int FLAGS_W = 4;

  // Bit positions inside the {zero, negative, carry, overflow} flag vector
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101
  } op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the arbitrated ALU.
// Requester i owns op bits [3i+2:3i] and operand bits [4i+3:4i].
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*OP_W-1:0]   req_op;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [DATA_W-1:0]      rsp_result;
  logic [FLAGS_W-1:0]     rsp_flags;
  logic                   rsp_op_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_op_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_op_err
  );

endinterface

// File: rtl/alu_unit.sv
// Combinational 4-bit ALU with {zero, negative, carry, overflow} flags.
// Illegal opcodes yield result 0 and raise op_err_o.
module alu_unit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  a_i,
  input  logic [DATA_W-1:0]  b_i,
  input  logic [OP_W-1:0]    op_i,
  output logic [DATA_W-1:0]  result_o,
  output logic [FLAGS_W-1:0] flags_o,
  output logic               op_err_o
);

  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] res;
  logic              carry;
  logic              ovf;
  logic              err;

  always_comb begin
    wide  = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    case (op_e'(op_i))
      OP_ADD: begin
        wide  = {1'b0, a_i} + {1'b0, b_i};
        res   = wide[DATA_W-1:0];
        carry = wide[DATA_W];
        ovf   = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (res[DATA_W-1] != a_i[DATA_W-1]);
      end
      OP_SUB: begin
        // carry means "no borrow", i.e. a >= b unsigned
        wide  = {1'b0, a_i} - {1'b0, b_i};
        res   = wide[DATA_W-1:0];
        carry = ~wide[DATA_W];
        ovf   = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (res[DATA_W-1] != a_i[DATA_W-1]);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_Z] = (res == '0);
    flags_o[FLAG_N] = res[DATA_W-1];
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_V] = ovf;
  end

  assign result_o = res;
  assign op_err_o = err;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a shared ALU with a single-entry response
// register; a new op can be accepted in the same cycle the response drains.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  logic [ID_W-1:0]    rr_q, rr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q;
  logic [DATA_W-1:0]  rsp_result_q;
  logic [FLAGS_W-1:0] rsp_flags_q;
  logic               rsp_op_err_q;

  logic [OP_W-1:0]    op_arr [NREQ];
  logic [DATA_W-1:0]  a_arr  [NREQ];
  logic [DATA_W-1:0]  b_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i] = bus.req_op[OP_W*i +: OP_W];
    assign a_arr[i]  = bus.req_a[DATA_W*i +: DATA_W];
    assign b_arr[i]  = bus.req_b[DATA_W*i +: DATA_W];
  end

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] idx;

  // Scan starting at rr; the 2-bit index wraps naturally modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_q + ID_W'(k);
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  logic slot_free;
  logic xfer;

  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  assign xfer      = slot_free && grant_found && !rst;

  assign bus.req_ready = xfer ? (NREQ'(1) << grant_id) : '0;

  logic [DATA_W-1:0]  alu_result;
  logic [FLAGS_W-1:0] alu_flags;
  logic               alu_err;

  alu_unit u_alu (
    .a_i      (a_arr[grant_id]),
    .b_i      (b_arr[grant_id]),
    .op_i     (op_arr[grant_id]),
    .result_o (alu_result),
    .flags_o  (alu_flags),
    .op_err_o (alu_err)
  );

  assign rr_d        = xfer ? grant_id + ID_W'(1) : rr_q;
  assign rsp_valid_d = xfer || (rsp_valid_q && !bus.rsp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_op_err_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      if (xfer) begin
        rsp_id_q     <= grant_id;
        rsp_result_q <= alu_result;
        rsp_flags_q  <= alu_flags;
        rsp_op_err_q <= alu_err;
      end
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_op_err = rsp_op_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_alu_arbiter;

  logic clk;
  logic rst;

  alu_arbiter_if bus_if ();

  alu_arbiter #(.NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {err, flags[3:0], result[3:0]} from plain integer arithmetic
  function automatic logic [8:0] model_alu(input int op, input int a, input int b);
    int sa, sb, r, c, v, e, f;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    r = 0; c = 0; v = 0; e = 0;
    case (op)
      0: begin r = (a + b) % 16; c = (a + b > 15); v = (sa + sb > 7) || (sa + sb < -8); end
      1: begin r = (a - b + 16) % 16; c = (a >= b); v = (sa - sb > 7) || (sa - sb < -8); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      default: begin e = 1; r = 0; end
    endcase
    f = ((r == 0) ? 8 : 0) + ((r >= 8) ? 4 : 0) + c * 2 + v;
    return 9'(e * 256 + f * 16 + r);
  endfunction

  // Model state, committed on rising edges
  bit cmp_on = 0;
  int m_rr, m_valid, m_id, m_res, m_flags, m_err;
  int n_rr, n_valid, n_id, n_res, n_flags, n_err;

  function automatic int model_ready();
    int j;
    if (rst || (m_valid != 0 && !bus_if.rsp_ready)) return 0;
    for (int k = 0; k < 4; k++) begin
      j = (m_rr + k) % 4;
      if (bus_if.req_valid[j]) return 1 << j;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    int exp_ready, g, op, a, b;
    logic [8:0] alu;
    if (cmp_on) begin
      exp_ready = model_ready();
      chk("req_ready", int'(bus_if.req_ready), exp_ready);
      chk("rsp_valid", int'(bus_if.rsp_valid), m_valid);
      chk("rsp_id", int'(bus_if.rsp_id), m_id);
      chk("rsp_result", int'(bus_if.rsp_result), m_res);
      chk("rsp_flags", int'(bus_if.rsp_flags), m_flags);
      chk("rsp_op_err", int'(bus_if.rsp_op_err), m_err);
      n_rr = m_rr; n_valid = m_valid; n_id = m_id;
      n_res = m_res; n_flags = m_flags; n_err = m_err;
      if (rst) begin
        n_rr = 0; n_valid = 0; n_id = 0; n_res = 0; n_flags = 0; n_err = 0;
      end else if (exp_ready != 0) begin
        g = 0;
        for (int k = 0; k < 4; k++) if (exp_ready == (1 << k)) g = k;
        op = int'((bus_if.req_op >> (3 * g)) & 12'h7);
        a  = int'((bus_if.req_a >> (4 * g)) & 16'hF);
        b  = int'((bus_if.req_b >> (4 * g)) & 16'hF);
        alu = model_alu(op, a, b);
        n_res = int'(alu[3:0]); n_flags = int'(alu[7:4]); n_err = int'(alu[8]);
        n_id = g; n_valid = 1; n_rr = (g + 1) % 4;
      end else if (bus_if.rsp_ready) begin
        n_valid = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (cmp_on) begin
      m_rr <= n_rr; m_valid <= n_valid; m_id <= n_id;
      m_res <= n_res; m_flags <= n_flags; m_err <= n_err;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int op, input int a, input int b);
    bus_if.req_op = (bus_if.req_op & ~(12'h7 << (3 * i))) | (12'(op & 7) << (3 * i));
    bus_if.req_a  = (bus_if.req_a & ~(16'hF << (4 * i))) | (16'(a & 15) << (4 * i));
    bus_if.req_b  = (bus_if.req_b & ~(16'hF << (4 * i))) | (16'(b & 15) << (4 * i));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.req_valid = '0;
    bus_if.req_op    = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_rr = 0; m_valid = 0; m_id = 0; m_res = 0; m_flags = 0; m_err = 0;
    cmp_on = 1;
    @(negedge clk);
    chk("reset_rsp_valid", int'(bus_if.rsp_valid), 0);
    chk("reset_req_ready", int'(bus_if.req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pin the reference model with hand-computed values
    chk("model_add_7_1", int'(model_alu(0, 7, 1)), 'h058);
    chk("model_sub_3_5", int'(model_alu(1, 3, 5)), 'h04E);
    chk("model_slt_8_1", int'(model_alu(5, 8, 1)), 'h001);
    chk("model_illegal", int'(model_alu(7, 3, 4)), 'h180);

    // ADD 7+1 from requester 0
    set_req(0, 0, 7, 1);
    bus_if.req_valid = 4'b0001;
    @(negedge clk);
    chk("add_ready", int'(bus_if.req_ready), 1);
    nxt();
    bus_if.req_valid = 4'b0000;
    @(negedge clk);
    chk("add_valid", int'(bus_if.rsp_valid), 1);
    chk("add_id", int'(bus_if.rsp_id), 0);
    chk("add_result", int'(bus_if.rsp_result), 8);
    chk("add_flags", int'(bus_if.rsp_flags), 4'b0101);
    chk("add_err", int'(bus_if.rsp_op_err), 0);
    nxt();

    // All four valid from reset: grants rotate 0,1,2,3,0,1
    pulse_rst();
    for (int i = 0; i < 4; i++) set_req(i, $urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 15));
    bus_if.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rot_grant", int'(bus_if.req_ready), 1 << (k % 4));
      if (k > 0) chk("rot_rsp_id", int'(bus_if.rsp_id), (k - 1) % 4);
      nxt();
    end
    bus_if.req_valid = 4'b0000;
    nxt();

    // Back-pressure: response held, req1 waits, granted when consumer accepts
    pulse_rst();
    set_req(0, 3, 5, 3);
    bus_if.req_valid = 4'b0001;
    bus_if.rsp_ready = 1'b0;
    nxt();
    set_req(1, 0, 1, 1);
    bus_if.req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", int'(bus_if.req_ready), 0);
      chk("stall_valid", int'(bus_if.rsp_valid), 1);
      chk("stall_result", int'(bus_if.rsp_result), 7);
      chk("stall_id", int'(bus_if.rsp_id), 0);
      nxt();
    end
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_grant", int'(bus_if.req_ready), 2);
    nxt();
    bus_if.req_valid = 4'b0000;
    @(negedge clk);
    chk("stall_next_id", int'(bus_if.rsp_id), 1);
    chk("stall_next_result", int'(bus_if.rsp_result), 2);
    nxt();

    // SUB 3-5 on requester 2, then SLT 0x8 vs 0x1 on requester 3
    set_req(2, 1, 3, 5);
    bus_if.req_valid = 4'b0100;
    nxt();
    set_req(3, 5, 8, 1);
    bus_if.req_valid = 4'b1000;
    @(negedge clk);
    chk("sub_id", int'(bus_if.rsp_id), 2);
    chk("sub_result", int'(bus_if.rsp_result), 14);
    chk("sub_flags", int'(bus_if.rsp_flags), 4'b0100);
    nxt();
    bus_if.req_valid = 4'b0000;
    @(negedge clk);
    chk("slt_id", int'(bus_if.rsp_id), 3);
    chk("slt_result", int'(bus_if.rsp_result), 1);
    nxt();

    // Reset while a response is pending, req1..3 valid
    set_req(0, 0, 2, 2);
    bus_if.req_valid = 4'b0001;
    bus_if.rsp_ready = 1'b0;
    nxt();
    rst = 1'b1;
    bus_if.req_valid = 4'b1110;
    @(negedge clk);
    chk("rst_ready_zero", int'(bus_if.req_ready), 0);
    chk("rst_pending_valid", int'(bus_if.rsp_valid), 1);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cleared_valid", int'(bus_if.rsp_valid), 0);
    chk("rst_first_grant", int'(bus_if.req_ready), 2);
    nxt();
    bus_if.req_valid = 4'b0000;
    bus_if.rsp_ready = 1'b1;
    nxt();

    // Illegal opcode on requester 0 still consumes a grant and advances rr
    pulse_rst();
    set_req(0, 7, 3, 4);
    bus_if.req_valid = 4'b0001;
    nxt();
    bus_if.req_valid = 4'b1111;
    @(negedge clk);
    chk("ill_result", int'(bus_if.rsp_result), 0);
    chk("ill_flags", int'(bus_if.rsp_flags), 4'b1000);
    chk("ill_err", int'(bus_if.rsp_op_err), 1);
    chk("ill_rr_next", int'(bus_if.req_ready), 2);
    nxt();
    bus_if.req_valid = 4'b0000;
    nxt();

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      bus_if.req_valid = 4'($urandom_range(0, 15));
      bus_if.req_op    = 12'($urandom);
      bus_if.req_a     = 16'($urandom);
      bus_if.req_b     = 16'($urandom);
      bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
      rst              = ($urandom_range(0, 63) == 0);
      nxt();
    end
    rst = 1'b0;
    bus_if.req_valid = 4'b0000;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
